// File: rtl/calc_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | calc_sequencer_pkg : state encoding and byte-count derivations     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package calc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // Two operands of WIDTH bits each are streamed in byte by byte.
  function automatic int nb_in(input int width);
    return (2 * width) / 8;
  endfunction

  function automatic int nb_out(input int width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_counter.sv
// +--------------------------------------------------------------------+
// | seq_counter : up-counter with clear, enable and terminal flag      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_counter #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int            CW = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] TC = CW'(MAX - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == TC) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC);

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// +--------------------------------------------------------------------+
// | calc_sequencer : load / compute / wait / shift-out sequencer       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [1:0] op_sel,
  input  logic       unit_done,
  output logic       in_shift_en,
  output logic       start_calc,
  output logic       output_result,
  output logic       unit_start,
  output logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam int NB_IN  = nb_in(WIDTH);
  localparam int NB_OUT = nb_out(WIDTH);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       load_q;
  logic       arm_q;
  logic       rise;
  logic       byte_tc, timer_tc, out_tc;

  // arm_q blocks a load_en that was already high across reset release.
  assign rise = load_en & ~load_q & arm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      load_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      load_q  <= load_en;
      arm_q   <= arm_q | ~load_en;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (rise) begin
          state_d = ST_LOAD;
          op_d    = op_sel;
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (byte_tc) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: state_d = ST_WAIT;
      ST_WAIT: begin
        if (unit_done) begin
          state_d = ST_OUTPUT;
        end else if (timer_tc) begin
          state_d = ST_ERROR;
        end
      end
      ST_OUTPUT: begin
        if (out_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  seq_counter #(.MAX(NB_IN)) u_byte_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != ST_LOAD),
    .en_i  (state_q == ST_LOAD),
    .tc_o  (byte_tc)
  );

  seq_counter #(.MAX(TIMEOUT)) u_timer_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != ST_WAIT),
    .en_i  (state_q == ST_WAIT),
    .tc_o  (timer_tc)
  );

  seq_counter #(.MAX(NB_OUT)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != ST_OUTPUT),
    .en_i  (state_q == ST_OUTPUT),
    .tc_o  (out_tc)
  );

  always_comb begin
    in_shift_en   = 1'b0;
    start_calc    = 1'b0;
    output_result = 1'b0;
    unit_start    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    timeout_err   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_shift_en = 1'b1;
        busy        = 1'b1;
      end
      ST_CALC: begin
        unit_start = 1'b1;
        start_calc = 1'b1;
        busy       = 1'b1;
      end
      ST_WAIT: begin
        start_calc = 1'b1;
        busy       = 1'b1;
      end
      ST_OUTPUT: begin
        output_result = 1'b1;
        start_calc    = 1'b1;
        busy          = 1'b1;
      end
      ST_DONE: begin
        done       = 1'b1;
        start_calc = 1'b1;
        busy       = 1'b1;
      end
      ST_ERROR: timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign op = op_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_calc_sequencer : randomized transactions vs. phase-timing model |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_calc_sequencer;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int NB_IN   = 2 * WIDTH / 8;
  localparam int NB_OUT  = WIDTH / 8;
  localparam int WS      = NB_IN + 2;  // first WAIT cycle after the rise

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CALC = 2, PH_WAIT = 3,
                 PH_OUT = 4, PH_DONE = 5, PH_ERR = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic [1:0] op_sel;
  logic       unit_done;
  logic       in_shift_en, start_calc, output_result, unit_start;
  logic [1:0] op;
  logic       busy, done, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] m_op;
  logic       m_err;
  logic [1:0] t_op;
  int         t_abort;
  int         t_delay;

  calc_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .op_sel        (op_sel),
    .unit_done     (unit_done),
    .in_shift_en   (in_shift_en),
    .start_calc    (start_calc),
    .output_result (output_result),
    .unit_start    (unit_start),
    .op            (op),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {op, in_shift_en, start_calc, output_result, unit_start, busy, done, timeout_err}
  function automatic logic [15:0] observed();
    return {7'd0, op, in_shift_en, start_calc, output_result, unit_start, busy, done, timeout_err};
  endfunction

  function automatic logic [15:0] from_phase(input int ph, input logic [1:0] o);
    logic [6:0] s;
    case (ph)
      PH_LOAD: s = 7'b1000100;
      PH_CALC: s = 7'b0101100;
      PH_WAIT: s = 7'b0100100;
      PH_OUT:  s = 7'b0110100;
      PH_DONE: s = 7'b0100110;
      PH_ERR:  s = 7'b0000001;
      default: s = 7'b0000000;
    endcase
    return {7'd0, o, s};
  endfunction

  // Phase of cycle c counted from the rise cycle, from the transaction's parameters.
  function automatic logic [15:0] expect_at(input int c);
    int ph;
    int wlen;
    wlen = (t_delay < TIMEOUT) ? t_delay + 1 : TIMEOUT;
    if (c == 0)                         ph = m_err ? PH_ERR : PH_IDLE;
    else if (t_abort >= 0)              ph = (c <= t_abort + 1) ? PH_LOAD : PH_IDLE;
    else if (c <= NB_IN)                ph = PH_LOAD;
    else if (c == NB_IN + 1)            ph = PH_CALC;
    else if (c < WS + wlen)             ph = PH_WAIT;
    else if (t_delay >= TIMEOUT)        ph = PH_ERR;
    else if (c < WS + wlen + NB_OUT)    ph = PH_OUT;
    else if (c == WS + wlen + NB_OUT)   ph = PH_DONE;
    else                                ph = PH_IDLE;
    return from_phase(ph, (c == 0) ? m_op : t_op);
  endfunction

  task automatic idle_gap(input int n);
    for (int g = 0; g < n; g++) begin
      #1;
      load_en   = 1'b0;
      op_sel    = 2'($urandom);
      unit_done = ($urandom % 3 == 0);
      #1;
      check_eq($sformatf("gap%0d", g), observed(), from_phase(m_err ? PH_ERR : PH_IDLE, m_op));
      @(posedge clk);
    end
  endtask

  task automatic run_txn(input logic [1:0] opv, input int abort_k, input int dly,
                         input int later_op, input int rst_at);
    int wlen, endc, last;
    t_op    = opv;
    t_abort = abort_k;
    t_delay = (dly > TIMEOUT) ? TIMEOUT : dly;
    wlen    = (t_delay < TIMEOUT) ? t_delay + 1 : TIMEOUT;
    endc    = (t_delay < TIMEOUT) ? WS + wlen + NB_OUT : WS + TIMEOUT;
    last    = (abort_k >= 0) ? abort_k + 1 : endc + 2;
    for (int c = 0; c <= last; c++) begin
      #1;
      if (abort_k >= 0)        load_en = (c <= abort_k);
      else if (c <= NB_IN)     load_en = 1'b1;
      else if (c >= endc - 1)  load_en = 1'b1;
      else                     load_en = (rst_at >= 0) ? 1'b1 : 1'($urandom);
      if (c == 0)              op_sel = opv;
      else if (later_op >= 0)  op_sel = 2'(later_op);
      else                     op_sel = 2'($urandom);
      if (abort_k < 0 && t_delay < TIMEOUT && c == WS + t_delay) unit_done = 1'b1;
      else if (abort_k < 0 && c >= WS && c < WS + wlen)         unit_done = 1'b0;
      else                                                      unit_done = ($urandom % 4 == 0);
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        check_eq("reset_mid", observed(), 16'd0);
        break;
      end
      #1;
      check_eq($sformatf("op%0d_c%0d", opv, c), observed(), expect_at(c));
      @(posedge clk);
    end
    m_op  = (abort_k < 0 && rst_at >= 0) ? 2'b00 : opv;
    m_err = (abort_k < 0 && rst_at < 0 && t_delay >= TIMEOUT);
    if (rst_at >= 0) begin
      @(posedge clk);
      #2;
      check_eq("reset_hold", observed(), 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        check_eq($sformatf("norestart%0d", k), observed(), 16'd0);
        @(posedge clk);
        #1;
      end
      @(posedge clk);
    end
    idle_gap(2 + $urandom % 3);
  endtask

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    op_sel    = 2'b00;
    unit_done = 1'b0;
    m_op      = 2'b00;
    m_err     = 1'b0;
    t_op      = 2'b00;
    t_abort   = -1;
    t_delay   = 0;
    #2;
    check_eq("reset_state", observed(), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    idle_gap(3);

    run_txn(2'b11, -1, 3, -1, -1);           // nominal
    run_txn(2'b01, 4, 0, -1, -1);            // abort in 5th LOAD cycle
    run_txn(2'b01, -1, TIMEOUT, -1, -1);     // timeout into ERROR
    run_txn(2'b00, -1, 0, -1, -1);           // rise out of ERROR, minimum latency
    run_txn(2'b11, -1, TIMEOUT - 1, -1, -1); // done on the last WAIT cycle
    run_txn(2'b10, -1, 2, 1, -1);            // op_sel changes during LOAD
    run_txn(2'b01, -1, 1, -1, WS + 3);       // reset in 2nd OUTPUT cycle

    for (int i = 0; i < 30; i++) begin
      int ab, d;
      ab = ($urandom % 4 == 0) ? int'($urandom % NB_IN) : -1;
      d  = ($urandom % 8 == 0) ? TIMEOUT - 2 + int'($urandom % 4) : int'($urandom % 12);
      run_txn(2'($urandom), ab, d, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
